// File: rtl/cpu_axil_master.sv
// CPU-style single-request initiator issuing AXI4-Lite master transactions into a host window.
// One transaction in flight; the response is held until the requester consumes it.
module cpu_axil_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [15:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      awaddr_m,
    output logic             awvalid_m,
    input  logic             awready_m,
    output logic [31:0]      wdata_m,
    output logic [3:0]       wstrb_m,
    output logic             wvalid_m,
    input  logic             wready_m,
    input  logic [1:0]       bresp_m,
    input  logic             bvalid_m,
    output logic             bready_m,
    output logic [31:0]      araddr_m,
    output logic             arvalid_m,
    input  logic             arready_m,
    input  logic [31:0]      rdata_m,
    input  logic [1:0]       rresp_m,
    input  logic             rvalid_m,
    output logic             rready_m,
    output logic [2:0]       fsm_state
);

    // Handshakes: a transfer happens on any rising clk edge where valid and ready are both high;
    // valid never drops before ready and its payload is frozen while valid is high.
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        rsp_load, rsp_err_nxt;
    logic [31:0] rsp_rdata_nxt;

    assign awaddr_m  = addr_q;
    assign araddr_m  = addr_q;
    assign wdata_m   = wdata_q;
    assign wstrb_m   = wstrb_q;
    assign fsm_state = state;

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        awvalid_m     = 1'b0;
        wvalid_m      = 1'b0;
        bready_m      = 1'b0;
        arvalid_m     = 1'b0;
        rready_m      = 1'b0;
        rsp_valid     = 1'b0;
        rsp_load      = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_write ? WR : RA;
            end
            WR: begin
                awvalid_m = !aw_done;
                wvalid_m  = !w_done;
                // AW and W may complete in either order or in the same cycle
                if ((aw_done || awready_m) && (w_done || wready_m)) state_nxt = WB;
            end
            WB: begin
                bready_m = 1'b1;
                if (bvalid_m) begin
                    state_nxt   = RSP;
                    rsp_load    = 1'b1;
                    rsp_err_nxt = (bresp_m != 2'b00);
                end
            end
            RA: begin
                arvalid_m = 1'b1;
                if (arready_m) state_nxt = RD;
            end
            RD: begin
                rready_m = 1'b1;
                if (rvalid_m) begin
                    state_nxt     = RSP;
                    rsp_load      = 1'b1;
                    rsp_rdata_nxt = rdata_m;
                    rsp_err_nxt   = (rresp_m != 2'b00);
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                addr_q  <= {BASE_ADDR[31:16], req_addr};
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR) begin
                aw_done <= aw_done || awready_m;
                w_done  <= w_done || wready_m;
            end
            if (rsp_load) begin
                rsp_rdata <= rsp_rdata_nxt;
                rsp_err   <= rsp_err_nxt;
                if (rsp_err_nxt && err_count != '1) err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_axil_master.sv
// Bench for cpu_axil_master: reactive AXI-Lite host with its own memory, offset-level reference
// model with an expected-response queue, directed cases followed by randomized traffic.
module tb_cpu_axil_master;
    localparam logic [31:0] BASE = 32'h0C00_0000;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  err_count;
    logic [31:0] awaddr_m, wdata_m, araddr_m, rdata_m;
    logic        awvalid_m, awready_m, wvalid_m, wready_m, bvalid_m, bready_m;
    logic        arvalid_m, arready_m, rvalid_m, rready_m;
    logic [3:0]  wstrb_m;
    logic [1:0]  bresp_m, rresp_m;
    logic [2:0]  fsm_state;

    always #5 clk = ~clk;

    cpu_axil_master #(.BASE_ADDR(BASE), .ERR_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_count(err_count),
        .awaddr_m(awaddr_m), .awvalid_m(awvalid_m), .awready_m(awready_m),
        .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wvalid_m(wvalid_m), .wready_m(wready_m),
        .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
        .araddr_m(araddr_m), .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rdata_m(rdata_m), .rresp_m(rresp_m), .rvalid_m(rvalid_m), .rready_m(rready_m),
        .fsm_state(fsm_state)
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: host contents per CPU offset, error region at offsets 0xExxx
    logic [31:0] ref_mem [logic [15:0]];
    int          ref_errs = 0;
    logic [32:0] exp_q [$];

    function automatic logic [32:0] ref_access(input logic wr, input logic [15:0] off,
                                               input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] full;
        logic [31:0] cur;
        full = {BASE[31:16], off};
        cur  = ref_mem.exists(off) ? ref_mem[off] : ~full;
        if (off[15:12] == 4'hE) begin
            ref_errs++;
            return {1'b1, wr ? 32'h0 : (32'hBAD0_0000 ^ full)};
        end
        if (wr) begin
            for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
            ref_mem[off] = cur;
            return {1'b0, 32'h0};
        end
        return {1'b0, cur};
    endfunction

    function automatic logic [7:0] sat_errs();
        return (ref_errs > 255) ? 8'hFF : 8'(ref_errs);
    endfunction

    // Host side: independent memory keyed by full AXI address, per-channel ready/valid delays
    logic [31:0] s_mem [logic [31:0]];
    bit          rnd = 0;
    int          dly_aw = 0, dly_w = 0, dly_b = 0, dly_ar = 0, dly_r = 0;
    int          b_count = 0;

    function automatic int pick(input int fixed);
        return rnd ? int'($urandom_range(0, 3)) : fixed;
    endfunction

    initial begin
        bit aw_have, w_have, ar_have, b_pend, r_pend, aw_arm, w_arm, ar_arm, p_aw, p_w, p_ar;
        int aw_wait, w_wait, ar_wait, b_wait, r_wait;
        logic [31:0] s_awaddr, s_wdata, s_araddr, p_awaddr, p_wdata, p_araddr, r_data, cur;
        logic [3:0]  s_wstrb, p_wstrb;
        logic [1:0]  b_resp, r_resp;
        {aw_have, w_have, ar_have, b_pend, r_pend, aw_arm, w_arm, ar_arm, p_aw, p_w, p_ar} = '0;
        {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
        awready_m = 0; wready_m = 0; arready_m = 0; bvalid_m = 0; rvalid_m = 0;
        bresp_m = 0; rresp_m = 0; rdata_m = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                {aw_have, w_have, ar_have, b_pend, r_pend, aw_arm, w_arm, ar_arm, p_aw, p_w, p_ar} = '0;
                awready_m = 0; wready_m = 0; arready_m = 0; bvalid_m = 0; rvalid_m = 0;
                continue;
            end
            if (p_aw) check("aw_stable", {awvalid_m, awaddr_m}, {1'b1, p_awaddr});
            if (p_w)  check("w_stable", {wvalid_m, wstrb_m, wdata_m}, {1'b1, p_wstrb, p_wdata});
            if (p_ar) check("ar_stable", {arvalid_m, araddr_m}, {1'b1, p_araddr});
            // B and R are evaluated before the address channels so a response never precedes its request handshake
            if (aw_have && w_have && !b_pend) begin
                b_pend = 1; b_wait = pick(dly_b);
                if (s_awaddr[15:12] == 4'hE) b_resp = 2'b10;
                else begin
                    b_resp = 2'b00;
                    cur = s_mem.exists(s_awaddr) ? s_mem[s_awaddr] : ~s_awaddr;
                    for (int b = 0; b < 4; b++) if (s_wstrb[b]) cur[8*b +: 8] = s_wdata[8*b +: 8];
                    s_mem[s_awaddr] = cur;
                end
            end
            bvalid_m = 0;
            if (b_pend) begin
                if (b_wait == 0) begin
                    bvalid_m = 1; bresp_m = b_resp;
                    if (bready_m) begin b_pend = 0; aw_have = 0; w_have = 0; b_count++; end
                end else b_wait--;
            end
            if (ar_have && !r_pend) begin
                r_pend = 1; r_wait = pick(dly_r);
                if (s_araddr[15:12] == 4'hE) begin r_resp = 2'b11; r_data = 32'hBAD0_0000 ^ s_araddr; end
                else begin r_resp = 2'b00; r_data = s_mem.exists(s_araddr) ? s_mem[s_araddr] : ~s_araddr; end
            end
            rvalid_m = 0;
            if (r_pend) begin
                if (r_wait == 0) begin
                    rvalid_m = 1; rdata_m = r_data; rresp_m = r_resp;
                    if (rready_m) begin r_pend = 0; ar_have = 0; end
                end else r_wait--;
            end
            awready_m = 0; p_aw = 0;
            if (awvalid_m && !aw_have) begin
                if (!aw_arm) begin aw_arm = 1; aw_wait = pick(dly_aw); end
                if (aw_wait == 0) begin awready_m = 1; aw_have = 1; aw_arm = 0; s_awaddr = awaddr_m; end
                else begin aw_wait--; p_aw = 1; p_awaddr = awaddr_m; end
            end
            wready_m = 0; p_w = 0;
            if (wvalid_m && !w_have) begin
                if (!w_arm) begin w_arm = 1; w_wait = pick(dly_w); end
                if (w_wait == 0) begin wready_m = 1; w_have = 1; w_arm = 0; s_wdata = wdata_m; s_wstrb = wstrb_m; end
                else begin w_wait--; p_w = 1; p_wdata = wdata_m; p_wstrb = wstrb_m; end
            end
            arready_m = 0; p_ar = 0;
            if (arvalid_m && !ar_have) begin
                if (!ar_arm) begin ar_arm = 1; ar_wait = pick(dly_ar); end
                if (ar_wait == 0) begin arready_m = 1; ar_have = 1; ar_arm = 0; s_araddr = araddr_m; end
                else begin ar_wait--; p_ar = 1; p_araddr = araddr_m; end
            end
        end
    end

    // Requester tasks: called and returning on a falling edge
    task automatic send(input logic wr, input logic [15:0] off, input logic [31:0] wd, input logic [3:0] ws);
        int n = 0;
        req_valid = 1; req_write = wr; req_addr = off; req_wdata = wd; req_wstrb = ws;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("req_accept", req_ready, 1);
            req_valid = 0;
            return;
        end
        exp_q.push_back(ref_access(wr, off, wd, ws));
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic get_rsp(input int hold);
        int n = 0;
        logic [32:0] e;
        if (exp_q.size() == 0) return;
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            check("rsp_timeout", rsp_valid, 1);
            exp_q.delete();
            return;
        end
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_err", rsp_err, e[32]);
        check("err_count", err_count, sat_errs());
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_hold", {rsp_valid, rsp_err, rsp_rdata, req_ready, awvalid_m, arvalid_m},
                  {1'b1, e[32], e[31:0], 3'b000});
        end
        req_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        logic        wr;
        logic [15:0] off;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        s_mem[32'h0C00_3000] = 32'hDEAD_BEEF;
        ref_mem[16'h3000]    = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {awvalid_m, wvalid_m, arvalid_m, bready_m, rready_m}, 5'b0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        check("rst_err_count", err_count, 8'h00);
        resetn = 1;
        @(negedge clk);

        // Read with every ready high: response three cycles after acceptance
        send(0, 16'h3000, 32'h0, 4'h0);
        check("t1_ar", {arvalid_m, araddr_m, rsp_valid}, {1'b1, 32'h0C00_3000, 1'b0});
        @(negedge clk);
        check("t1_rd", {arvalid_m, rready_m, rsp_valid}, 3'b010);
        @(negedge clk);
        check("t1_latency", rsp_valid, 1);
        get_rsp(0);

        // Write with W accepted five cycles after AW
        dly_w = 5; b0 = b_count;
        send(1, 16'h0010, 32'h1234_5678, 4'b0011);
        @(negedge clk);
        check("t2_w_held", {awvalid_m, wvalid_m, wdata_m, wstrb_m}, {2'b01, 32'h1234_5678, 4'b0011});
        get_rsp(0);
        check("t2_one_b", b_count - b0, 1);
        dly_w = 0;
        send(0, 16'h0010, 32'h0, 4'h0);
        get_rsp(0);

        // Error responses and counter saturation
        send(1, 16'hE000, 32'h1, 4'hF);
        get_rsp(0);
        check("t3_err1", {rsp_err, err_count}, {1'b1, 8'd1});
        send(0, 16'hE004, 32'h0, 4'h0);
        get_rsp(0);
        check("t3_err2", err_count, 8'd2);
        for (int i = 0; i < 300; i++) begin
            send(1'(i % 2), 16'hE000 | 16'((i * 4) & 12'hFFC), $urandom, 4'hF);
            get_rsp(0);
        end
        check("t3_sat", err_count, 8'hFF);

        // Response backpressure with a competing request held by the requester
        send(0, 16'h0020, 32'h0, 4'h0);
        req_valid = 1; req_write = 1; req_addr = 16'h0030; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
        get_rsp(10);
        @(negedge clk);
        check("t4_not_taken", {awvalid_m, arvalid_m, req_ready}, 3'b001);

        // Reset while waiting for B drops the transaction without a response
        dly_b = 6;
        send(1, 16'h7000, 32'h5555_AAAA, 4'hF);
        n = 0;
        while (!bready_m && n < 50) begin @(negedge clk); n++; end
        check("t5_in_wb", bready_m, 1);
        resetn = 0;
        @(negedge clk);
        check("t5_reset", {awvalid_m, wvalid_m, arvalid_m, bready_m, rready_m, rsp_valid, req_ready},
              7'b0000001);
        check("t5_err_clr", err_count, 8'h00);
        exp_q.delete();
        ref_errs = 0;
        dly_b = 0;
        resetn = 1;
        @(negedge clk);
        check("t5_no_rsp", rsp_valid, 0);
        send(0, 16'h0004, 32'h0, 4'h0);
        get_rsp(0);

        // Randomized mixed traffic with random host and requester delays
        rnd = 1;
        for (int i = 0; i < 1000; i++) begin
            wr  = 1'($urandom_range(0, 1));
            off = 16'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) off[15:12] = 4'hE;
            send(wr, off, $urandom, 4'($urandom_range(0, 15)));
            get_rsp(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check("t6_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
